// File: rtl/fm_backward_search_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fm_backward_search_if                                 |
// | Brief    : Control, query-symbol, rom_C, Occ and result bus.     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface fm_backward_search_if #(
   parameter int PTR_W = 8
);
   logic             start;
   logic [PTR_W-1:0] ref_len;

   logic             sym_valid;
   logic [1:0]       sym;
   logic             sym_last;
   logic             sym_ready;

   logic             c_ce;
   logic [1:0]       c_symbol;
   logic [PTR_W-1:0] c_data;

   logic             occ_ce;
   logic [1:0]       occ_symbol;
   logic [PTR_W-1:0] occ_addr;
   logic [PTR_W-1:0] occ_data;

   logic             busy;
   logic             done;
   logic             found;
   logic [PTR_W-1:0] top;
   logic [PTR_W-1:0] bot;
   logic [PTR_W-1:0] count;

   // Search engine side: it masters the query stream and both memories.
   modport master (
      input  start, ref_len, sym_valid, sym, sym_last, c_data, occ_data,
      output sym_ready, c_ce, c_symbol, occ_ce, occ_symbol, occ_addr,
      output busy, done, found, top, bot, count
   );

   modport slave (
      output start, ref_len, sym_valid, sym, sym_last, c_data, occ_data,
      input  sym_ready, c_ce, c_symbol, occ_ce, occ_symbol, occ_addr,
      input  busy, done, found, top, bot, count
   );
endinterface

`default_nettype wire

// File: rtl/fm_backward_search.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fm_backward_search                                    |
// | Brief    : FM-index backward search, one symbol per 4 cycles.    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module fm_backward_search #(
   parameter int PTR_W = 8
) (
   input wire                   clk,
   input wire                   rst,
   fm_backward_search_if.master bus
);
   localparam logic [2:0] c_idle     = 3'd0;
   localparam logic [2:0] c_wait_sym = 3'd1;
   localparam logic [2:0] c_rd_top   = 3'd2;
   localparam logic [2:0] c_rd_bot   = 3'd3;
   localparam logic [2:0] c_update   = 3'd4;
   localparam logic [2:0] c_done     = 3'd5;

   logic [2:0]       r_state;
   logic [2:0]       w_next;

   logic [PTR_W-1:0] r_top;
   logic [PTR_W-1:0] r_bot;
   logic [PTR_W-1:0] r_occ_top;
   logic [PTR_W-1:0] r_occ_bot;
   logic [1:0]       r_sym;
   logic             r_last;
   logic             r_hit;

   logic             r_done;
   logic             r_found;
   logic [PTR_W-1:0] r_res_top;
   logic [PTR_W-1:0] r_res_bot;
   logic [PTR_W-1:0] r_res_count;

   logic             w_xfer;
   logic [PTR_W:0]   w_new_top;
   logic [PTR_W:0]   w_new_bot;
   logic             w_ovf;
   logic             w_empty;
   logic             w_fail;

   assign w_xfer = (r_state == c_wait_sym) && bus.sym_valid;

   // One extra bit so a carry out of either sum is seen as overflow.
   assign w_new_top = {1'b0, bus.c_data} + {1'b0, r_occ_top};
   assign w_new_bot = {1'b0, bus.c_data} + {1'b0, r_occ_bot};
   assign w_ovf     = w_new_top[PTR_W] | w_new_bot[PTR_W];
   assign w_empty   = (w_new_top >= w_new_bot);
   assign w_fail    = w_ovf | w_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle: begin
            if (bus.start) begin
               w_next = c_wait_sym;
            end
         end
         c_wait_sym: begin
            if (w_xfer) begin
               w_next = c_rd_top;
            end
         end
         c_rd_top: begin
            w_next = c_rd_bot;
         end
         c_rd_bot: begin
            w_next = c_update;
         end
         c_update: begin
            if (w_fail || r_last) begin
               w_next = c_done;
            end else begin
               w_next = c_wait_sym;
            end
         end
         c_done: begin
            w_next = c_idle;
         end
         default: begin
            w_next = c_idle;
         end
      endcase
   end

   always_comb begin
      bus.sym_ready  = 1'b0;
      bus.c_ce       = 1'b0;
      bus.c_symbol   = 2'd0;
      bus.occ_ce     = 1'b0;
      bus.occ_symbol = 2'd0;
      bus.occ_addr   = '0;
      bus.busy       = (r_state != c_idle);
      case (r_state)
         c_wait_sym: begin
            bus.sym_ready = 1'b1;
            if (bus.sym_valid) begin
               bus.occ_ce     = 1'b1;
               bus.occ_symbol = bus.sym;
               bus.occ_addr   = r_top;
            end
         end
         c_rd_top: begin
            bus.occ_ce     = 1'b1;
            bus.occ_symbol = r_sym;
            bus.occ_addr   = r_bot;
         end
         c_update: begin
            bus.c_ce     = 1'b1;
            bus.c_symbol = r_sym;
         end
         default: begin
         end
      endcase
   end

   // Interval, captured Occ counts and the held result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_top       <= '0;
         r_bot       <= '0;
         r_occ_top   <= '0;
         r_occ_bot   <= '0;
         r_sym       <= 2'd0;
         r_last      <= 1'b0;
         r_hit       <= 1'b0;
         r_done      <= 1'b0;
         r_found     <= 1'b0;
         r_res_top   <= '0;
         r_res_bot   <= '0;
         r_res_count <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_idle: begin
               if (bus.start) begin
                  r_top       <= '0;
                  r_bot       <= bus.ref_len;
                  r_hit       <= 1'b0;
                  r_found     <= 1'b0;
                  r_res_top   <= '0;
                  r_res_bot   <= '0;
                  r_res_count <= '0;
               end
            end
            c_wait_sym: begin
               if (bus.sym_valid) begin
                  r_sym  <= bus.sym;
                  r_last <= bus.sym_last;
               end
            end
            c_rd_top: begin
               r_occ_top <= bus.occ_data;
            end
            c_rd_bot: begin
               r_occ_bot <= bus.occ_data;
            end
            c_update: begin
               if (w_fail) begin
                  r_hit <= 1'b0;
               end else begin
                  r_top <= w_new_top[PTR_W-1:0];
                  r_bot <= w_new_bot[PTR_W-1:0];
                  r_hit <= r_last;
               end
            end
            c_done: begin
               r_done      <= 1'b1;
               r_found     <= r_hit;
               r_res_top   <= r_top;
               r_res_bot   <= r_bot;
               r_res_count <= r_hit ? (r_bot - r_top) : '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.done  = r_done;
   assign bus.found = r_found;
   assign bus.top   = r_res_top;
   assign bus.bot   = r_res_bot;
   assign bus.count = r_res_count;

endmodule

`default_nettype wire

// File: tb/tb_fm_backward_search.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_fm_backward_search                                 |
// | Brief    : Scoreboard bench over text "ACGA$", BWT "AG$AC".      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_fm_backward_search;
   localparam int PTR_W = 8;

   typedef struct {
      string      name;
      logic       found;
      logic [7:0] top;
      logic [7:0] bot;
      logic [7:0] count;
      bit         chk_iv;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic occ_stub;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [7:0] occ_log[$];
   int   cce_cnt = 0;

   always #5 clk = ~clk;

   fm_backward_search_if #(.PTR_W(PTR_W)) bus ();

   fm_backward_search #(.PTR_W(PTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [7:0] c_f(input logic [1:0] s);
      case (s)
         2'd0:    return 8'd1;
         2'd1:    return 8'd3;
         2'd2:    return 8'd4;
         default: return 8'd5;
      endcase
   endfunction

   // BWT "AG$AC"; the sentinel is coded 4 so it never matches a symbol.
   function automatic logic [7:0] occ_f(input logic [1:0] s, input logic [7:0] a);
      logic [2:0] bwt [5];
      int n;
      bwt[0] = 3'd0; bwt[1] = 3'd2; bwt[2] = 3'd4; bwt[3] = 3'd0; bwt[4] = 3'd1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (i < int'(a) && bwt[i] == {1'b0, s}) n++;
      end
      return n[7:0];
   endfunction

   assign bus.c_data = occ_stub ? 8'd1 : c_f(bus.c_symbol);

   always @(posedge clk) begin
      if (bus.occ_ce === 1'b1) begin
         bus.occ_data <= occ_stub ? 8'hFF : occ_f(bus.occ_symbol, bus.occ_addr);
      end
   end

   always @(negedge clk) begin
      if (bus.occ_ce === 1'b1) occ_log.push_back(bus.occ_addr);
      if (bus.c_ce === 1'b1) cce_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_busy"},      32'(bus.busy),      0);
      check({pfx, "_done"},      32'(bus.done),      0);
      check({pfx, "_found"},     32'(bus.found),     0);
      check({pfx, "_top"},       32'(bus.top),       0);
      check({pfx, "_bot"},       32'(bus.bot),       0);
      check({pfx, "_count"},     32'(bus.count),     0);
      check({pfx, "_sym_ready"}, 32'(bus.sym_ready), 0);
      check({pfx, "_c_ce"},      32'(bus.c_ce),      0);
      check({pfx, "_occ_ce"},    32'(bus.occ_ce),    0);
   endtask

   // Result monitor: every done pulse is matched against the oldest expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
               e = sb.pop_front();
               check({e.name, "_found"}, 32'(bus.found), 32'(e.found));
               check({e.name, "_count"}, 32'(bus.count), 32'(e.count));
               if (e.chk_iv) begin
                  check({e.name, "_top"}, 32'(bus.top), 32'(e.top));
                  check({e.name, "_bot"}, 32'(bus.bot), 32'(e.bot));
               end
            end
         end
      end
   end

   task automatic run_query(input string name, input logic [7:0] rl,
                            input logic [1:0] s0, input logic [1:0] s1, input int nsym,
                            input int pre, input bit pulse,
                            input logic efound, input logic [7:0] etop, input logic [7:0] ebot,
                            input logic [7:0] ecount, input bit chk_iv,
                            input int elat, input int exfer);
      exp_t       e;
      logic [1:0] syms [2];
      int         lat;
      int         xfer;
      bit         got;
      syms[0] = s0;
      syms[1] = s1;
      e.name = name; e.found = efound; e.top = etop; e.bot = ebot;
      e.count = ecount; e.chk_iv = chk_iv;
      sb.push_back(e);
      lat = 0; xfer = 0; got = 1'b0;
      @(posedge clk); #1;
      bus.ref_len = rl;
      bus.start   = 1'b1;
      fork
         begin
            @(posedge clk); #1;
            bus.start = 1'b0;
         end
         begin
            if (pre > 0) begin
               bus.sym_valid = 1'b0;
               repeat (pre) @(posedge clk);
               #1;
            end
            for (int k = 0; k < nsym; k++) begin
               int w;
               bit ok;
               bus.sym       = syms[k];
               bus.sym_last  = (k == nsym - 1);
               bus.sym_valid = 1'b1;
               ok = 1'b0;
               w  = 0;
               while (!ok && w < 12) begin
                  @(negedge clk);
                  if (bus.sym_ready === 1'b1) ok = 1'b1;
                  @(posedge clk); #1;
                  w++;
               end
               bus.sym_valid = 1'b0;
               if (!ok) break;
               xfer++;
               if (pulse && k == 0) begin
                  bus.start = 1'b1;
                  @(posedge clk); #1;
                  bus.start = 1'b0;
               end
            end
         end
         begin
            while (!got && lat < 100) begin
               @(posedge clk);
               lat++;
               @(negedge clk);
               if (bus.done === 1'b1) got = 1'b1;
            end
         end
      join
      check({name, "_done_seen"}, 32'(got), 1);
      if (!got && sb.size() > 0) e = sb.pop_back();
      if (elat > 0) check({name, "_latency"}, lat, elat);
      check({name, "_symbols_taken"}, xfer, exfer);
   endtask

   initial begin : stim
      int o0;
      int c0;
      rst           = 1'b1;
      occ_stub      = 1'b0;
      bus.start     = 1'b0;
      bus.ref_len   = '0;
      bus.sym_valid = 1'b0;
      bus.sym       = 2'd0;
      bus.sym_last  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("por");
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // "GA": A then G -> [4,5)
      o0 = occ_log.size(); c0 = cce_cnt;
      run_query("ga", 8'd5, 2'd0, 2'd2, 2, 0, 1'b0, 1'b1, 8'd4, 8'd5, 8'd1, 1'b1, 10, 2);
      check("ga_occ_reads", occ_log.size() - o0, 4);
      if (occ_log.size() - o0 == 4) begin
         check("ga_occ_addr0", 32'(occ_log[o0]),   0);
         check("ga_occ_addr1", 32'(occ_log[o0+1]), 5);
         check("ga_occ_addr2", 32'(occ_log[o0+2]), 1);
         check("ga_occ_addr3", 32'(occ_log[o0+3]), 3);
      end
      check("ga_c_reads", cce_cnt - c0, 2);

      // "T": [5,5) empty on the first symbol
      o0 = occ_log.size(); c0 = cce_cnt;
      run_query("t", 8'd5, 2'd3, 2'd0, 1, 0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 6, 1);
      check("t_occ_reads", occ_log.size() - o0, 2);
      if (occ_log.size() - o0 == 2) begin
         check("t_occ_addr0", 32'(occ_log[o0]),   0);
         check("t_occ_addr1", 32'(occ_log[o0+1]), 5);
      end
      check("t_c_reads", cce_cnt - c0, 1);

      // "AA": [1,3) then [2,2)
      run_query("aa", 8'd5, 2'd0, 2'd0, 2, 0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 10, 2);

      // "AT" fed T first: fails at once, the trailing A is never taken
      run_query("ta", 8'd5, 2'd3, 2'd0, 2, 0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 6, 1);

      // "C": [3,4), then the result must hold after done
      run_query("c", 8'd5, 2'd1, 2'd0, 1, 0, 1'b0, 1'b1, 8'd3, 8'd4, 8'd1, 1'b1, 6, 1);
      repeat (3) @(negedge clk);
      check("c_hold_found", 32'(bus.found), 1);
      check("c_hold_top",   32'(bus.top),   3);
      check("c_hold_count", 32'(bus.count), 1);
      check("c_hold_done",  32'(bus.done),  0);

      // "GA" with a 3-cycle stall in WAIT_SYM and a stray start in RD_TOP
      run_query("ga_stall", 8'd5, 2'd0, 2'd2, 2, 4, 1'b1, 1'b1, 8'd4, 8'd5, 8'd1, 1'b1, 0, 2);

      // ref_len = 0: first update is empty
      run_query("len0", 8'd0, 2'd1, 2'd0, 1, 0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 6, 1);

      // Occ stub 255 with c_data 1 overflows
      occ_stub = 1'b1;
      run_query("ovf", 8'd5, 2'd0, 2'd0, 1, 0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 6, 1);
      occ_stub = 1'b0;

      // Reset during RD_BOT, then a fresh "GA"
      @(posedge clk); #1;
      bus.ref_len   = 8'd5;
      bus.start     = 1'b1;
      bus.sym       = 2'd0;
      bus.sym_last  = 1'b0;
      bus.sym_valid = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.sym_valid = 1'b0;
      @(posedge clk); #1;
      check("rd_bot_busy",   32'(bus.busy),   1);
      check("rd_bot_occ_ce", 32'(bus.occ_ce), 0);
      #2 rst = 1'b1;
      #1 check_zero("rst_async");
      @(negedge clk);
      check_zero("rst_held");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      run_query("ga_after_rst", 8'd5, 2'd0, 2'd2, 2, 0, 1'b0, 1'b1, 8'd4, 8'd5, 8'd1, 1'b1, 10, 2);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
